// File: rtl/mmio_game_io.sv
// mmio_game_io: memory-mapped game peripheral. It debounces the buttons into a
// press-event FIFO, drives LEDs that are steady or timed, and exposes a
// free-running 32-bit LFSR. Four word addresses are decoded from the data-memory bus.
module mmio_game_io #(
  parameter int          N_CH       = 4,
  parameter int          DB_CYCLES  = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [11:0] RAND_ADDR  = 12'd5,
  parameter logic [11:0] LED_ADDR   = 12'd6,
  parameter logic [11:0] BTN_ADDR   = 12'd7,
  parameter logic [11:0] STAT_ADDR  = 12'd8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] buttons,
  output logic [N_CH-1:0] leds,
  input  logic [11:0]     addr,
  input  logic            wren,
  input  logic            rden,
  input  logic [31:0]     data_in,
  output logic [31:0]     data_out,
  output logic            hit
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);

  logic [N_CH-1:0]   sync_p0, sync_p1, stable, pending, rise, svc_onehot;
  logic [CNT_W-1:0]  db_cnt [N_CH];
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              overflow;
  logic [15:0]       led_timer [N_CH];
  logic [31:0]       lfsr;
  logic              svc_vld;
  logic [7:0]        svc_ch;
  logic              fifo_full, fifo_empty, push, pop, ovf_evt, led_wr, stat_clr;
  logic [31:0]       btn_word, stat_word;
  logic              unused_bits;

  assign fifo_full   = (fifo_cnt == FIFO_FULL_CNT);
  assign fifo_empty  = (fifo_cnt == '0);
  assign pop         = rden && (addr == BTN_ADDR) && !fifo_empty;
  assign push        = svc_vld && !fifo_full;
  assign ovf_evt     = svc_vld && fifo_full;
  assign led_wr      = wren && (addr == LED_ADDR);
  assign stat_clr    = wren && (addr == STAT_ADDR) && data_in[0];
  assign unused_bits = ^data_in[15:9];

  // Two-flop synchronizer on the raw button inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= buttons;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept a new level after DB_CYCLES consecutive differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press detect: the stable level is about to go 0->1 this cycle
  always_comb begin
    rise = '0;
    for (int i = 0; i < N_CH; i++)
      rise[i] = sync_p1[i] && !stable[i] && (db_cnt[i] == DB_LAST);
  end

  // Lowest-index pending channel is serviced each cycle
  always_comb begin
    svc_vld    = 1'b0;
    svc_ch     = '0;
    svc_onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pending[i] && !svc_vld) begin
        svc_vld       = 1'b1;
        svc_ch        = 8'(i);
        svc_onehot[i] = 1'b1;
      end
    end
  end

  // Pending bits: set on press, cleared when serviced (pushed or dropped)
  always_ff @(posedge clock) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~svc_onehot) | rise;
  end

  // Event FIFO storage (data only, no reset needed)
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= svc_ch;
  end

  // Event FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clock) begin
    if (reset)         overflow <= 1'b0;
    else if (ovf_evt)  overflow <= 1'b1;
    else if (stat_clr) overflow <= 1'b0;
  end

  // LED control: writes override, nonzero timer lights the LED for exactly that many cycles
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        leds[i]      <= 1'b0;
        led_timer[i] <= '0;
      end else if (led_wr && (data_in[7:0] == 8'(i))) begin
        leds[i]      <= data_in[8];
        led_timer[i] <= data_in[8] ? data_in[31:16] : 16'd0;
      end else if (led_timer[i] == 16'd1) begin
        leds[i]      <= 1'b0;
        led_timer[i] <= '0;
      end else if (led_timer[i] != 16'd0) begin
        led_timer[i] <= led_timer[i] - 16'd1;
      end
    end
  end

  // Free-running LFSR, taps 32,22,2,1, shifting left
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 32'hACE1_0001;
    else       lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  end

  // Read words for the event and status registers
  always_comb begin
    btn_word  = fifo_empty ? 32'd0 : {1'b1, 23'd0, fifo_mem[rd_ptr]};
    stat_word = '0;
    stat_word[0]           = overflow;
    stat_word[15:8]        = 8'(fifo_cnt);
    stat_word[16 +: N_CH]  = stable;
  end

  // Address decode and read mux
  always_comb begin
    data_out = '0;
    hit      = 1'b1;
    if (addr == RAND_ADDR)      data_out = lfsr;
    else if (addr == LED_ADDR)  data_out = 32'(leds);
    else if (addr == BTN_ADDR)  data_out = btn_word;
    else if (addr == STAT_ADDR) data_out = stat_word;
    else                        hit      = 1'b0;
  end

endmodule

// File: tb/tb_mmio_game_io.sv
// tb_mmio_game_io: directed and randomized bench for mmio_game_io with an
// event-level reference model (sample run lengths, event queue, LED end times).
module tb_mmio_game_io;

  localparam int N_CH = 4;
  localparam int DB   = 16;
  localparam int FD   = 8;
  localparam logic [11:0] A_RAND = 12'd5;
  localparam logic [11:0] A_LED  = 12'd6;
  localparam logic [11:0] A_BTN  = 12'd7;
  localparam logic [11:0] A_STAT = 12'd8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N_CH-1:0] buttons = '0;
  logic [N_CH-1:0] leds;
  logic [11:0]     addr = '0;
  logic            wren = 1'b0;
  logic            rden = 1'b0;
  logic [31:0]     data_in = '0;
  logic [31:0]     data_out;
  logic            hit;

  int n_cmp = 0;
  int n_err = 0;

  mmio_game_io #(
    .N_CH(N_CH), .DB_CYCLES(DB), .FIFO_DEPTH(FD),
    .RAND_ADDR(A_RAND), .LED_ADDR(A_LED), .BTN_ADDR(A_BTN), .STAT_ADDR(A_STAT)
  ) dut (
    .clock(clock), .reset(reset), .buttons(buttons), .leds(leds),
    .addr(addr), .wren(wren), .rden(rden), .data_in(data_in),
    .data_out(data_out), .hit(hit)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit          m_s1 [N_CH];
  bit          m_s2 [N_CH];
  bit          m_st [N_CH];
  int          m_run [N_CH];
  bit          m_pend [N_CH];
  int          m_mode [N_CH];   // 0 off, 1 steady, 2 timed
  int          m_end [N_CH];
  int          q[$];
  bit          m_ovf;
  bit [31:0]   m_lfsr;
  int          cyc = 0;

  task automatic model_step();
    int  svc;
    bit  full;
    bit  ovfevt;
    int  ch;
    cyc++;
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0; m_pend[i] = 0; m_mode[i] = 0;
      end
      q.delete();
      m_ovf  = 0;
      m_lfsr = 32'hACE1_0001;
    end else begin
      svc = -1;
      for (int i = N_CH - 1; i >= 0; i--) if (m_pend[i]) svc = i;
      full   = (q.size() >= FD);
      ovfevt = 0;
      if (rden && addr == A_BTN && q.size() > 0) void'(q.pop_front());
      if (svc >= 0) begin
        m_pend[svc] = 0;
        if (!full) q.push_back(svc);
        else ovfevt = 1;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (m_s2[i] == m_st[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_st[i]  = m_s2[i];
            m_run[i] = 0;
            if (m_st[i]) m_pend[i] = 1;
          end
        end
      end
      if (ovfevt) m_ovf = 1;
      else if (wren && addr == A_STAT && data_in[0]) m_ovf = 0;
      if (wren && addr == A_LED && int'(data_in[7:0]) < N_CH) begin
        ch = int'(data_in[7:0]);
        if (!data_in[8]) m_mode[ch] = 0;
        else if (data_in[31:16] == 16'd0) m_mode[ch] = 1;
        else begin
          m_mode[ch] = 2;
          m_end[ch]  = cyc + int'(data_in[31:16]);
        end
      end
      m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
      for (int i = 0; i < N_CH; i++) begin
        m_s2[i] = m_s1[i];
        m_s1[i] = buttons[i];
      end
    end
  endtask

  always @(posedge clock) model_step();

  function automatic logic [31:0] exp_read(logic [11:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == A_RAND) r = m_lfsr;
    else if (a == A_BTN) begin
      if (q.size() > 0) r = 32'h8000_0000 | 32'(q[0]);
    end else if (a == A_STAT) begin
      r = 32'(m_ovf) | (32'(q.size()) << 8);
      for (int i = 0; i < N_CH; i++) if (m_st[i]) r = r | (32'd1 << (16 + i));
    end
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_leds();
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++)
      r[i] = (m_mode[i] == 1) || (m_mode[i] == 2 && cyc < m_end[i]);
    return r;
  endfunction

  task automatic set_bus(input logic [11:0] a, input logic r, input logic w, input logic [31:0] d);
    addr = a; rden = r; wren = w; data_in = d;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic release_all();
    buttons = '0;
    set_bus(12'd0, 1'b0, 1'b0, 32'd0);
    repeat (DB + 4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    buttons = '0;
    set_bus(A_STAT, 1'b0, 1'b0, 32'd0);
    step(); step();
    n_cmp++; if (leds !== '0) begin n_err++; $display("FAIL reset_leds: got %h expected 0", leds); end
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL reset_stat: got %h expected 0", data_out); end
    reset = 1'b0;
    set_bus(A_RAND, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'hACE1_0001) begin n_err++; $display("FAIL rand_first: got %h expected ACE10001", data_out); end
    step();
    set_bus(A_RAND, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'h59C2_0003) begin n_err++; $display("FAIL rand_second: got %h expected 59C20003", data_out); end
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++;
      if (data_out !== exp_read(A_RAND) || data_out === 32'd0) begin
        n_err++; $display("FAIL rand_seq: got %h expected %h", data_out, exp_read(A_RAND));
      end
    end
    set_bus(A_BTN, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL reset_btn: got %h expected 0", data_out); end
  endtask

  task automatic test_press_single();
    set_bus(12'd0, 1'b0, 1'b0, 32'd0);
    buttons[2] = 1'b1;
    repeat (DB + 4) step();
    set_bus(A_BTN, 1'b1, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'h8000_0002) begin n_err++; $display("FAIL press_single_head: got %h expected 80000002", data_out); end
    step();
    set_bus(A_BTN, 1'b1, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL press_single_empty: got %h expected 0", data_out); end
    release_all();
  endtask

  task automatic test_bounce();
    set_bus(A_STAT, 1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 100; c++) begin
      if (c % 5 == 0) buttons[0] = ~buttons[0];
      step();
      if (c % 10 == 9) begin
        n_cmp++;
        if (data_out[15:8] !== 8'd0 || data_out !== exp_read(A_STAT)) begin
          n_err++; $display("FAIL bounce_stat: got %h expected %h", data_out, exp_read(A_STAT));
        end
      end
    end
    release_all();
    set_bus(A_BTN, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL bounce_no_event: got %h expected 0", data_out); end
  endtask

  task automatic test_same_cycle();
    buttons = 4'b1010;
    repeat (DB + 6) step();
    set_bus(A_BTN, 1'b1, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'h8000_0001) begin n_err++; $display("FAIL order_first: got %h expected 80000001", data_out); end
    step();
    n_cmp++; if (data_out !== 32'h8000_0003) begin n_err++; $display("FAIL order_second: got %h expected 80000003", data_out); end
    step();
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL order_empty: got %h expected 0", data_out); end
    release_all();
  endtask

  task automatic test_overflow();
    for (int p = 0; p < FD + 2; p++) begin
      buttons[0] = 1'b1;
      repeat (DB + 4) step();
      buttons[0] = 1'b0;
      repeat (DB + 4) step();
    end
    set_bus(A_STAT, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'h0000_0801) begin n_err++; $display("FAIL ovf_stat: got %h expected 00000801", data_out); end
    set_bus(A_STAT, 1'b0, 1'b1, 32'h1);
    step();
    set_bus(A_STAT, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'h0000_0800) begin n_err++; $display("FAIL ovf_clear: got %h expected 00000800", data_out); end
    for (int k = 0; k < FD; k++) begin
      set_bus(A_BTN, 1'b1, 1'b0, 32'd0);
      n_cmp++; if (data_out !== 32'h8000_0000) begin n_err++; $display("FAIL drain_head: got %h expected 80000000", data_out); end
      step();
    end
    set_bus(A_STAT, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL drain_stat: got %h expected 0", data_out); end
  endtask

  task automatic test_led();
    set_bus(A_LED, 1'b0, 1'b1, 32'h0005_0101);
    step();
    for (int k = 0; k < 7; k++) begin
      set_bus(12'd0, 1'b0, 1'b0, 32'd0);
      n_cmp++;
      if (leds[1] !== (k < 5) || leds !== exp_leds()) begin
        n_err++; $display("FAIL led_pulse k=%0d: got %b expected %b", k, leds, exp_leds());
      end
      step();
    end
    set_bus(A_LED, 1'b0, 1'b1, 32'h0005_0101);
    step(); step();
    set_bus(A_LED, 1'b0, 1'b1, 32'h0000_0100);
    step();
    for (int k = 0; k < 10; k++) begin
      set_bus(12'd0, 1'b0, 1'b0, 32'd0);
      n_cmp++;
      if (leds[0] !== 1'b1 || leds !== exp_leds()) begin
        n_err++; $display("FAIL led_steady k=%0d: got %b expected %b", k, leds, exp_leds());
      end
      step();
    end
    set_bus(A_LED, 1'b0, 1'b1, 32'h0003_0102);
    step();
    set_bus(A_LED, 1'b0, 1'b1, 32'h0000_0002);
    step();
    set_bus(A_LED, 1'b0, 1'b1, 32'h0000_0104);
    n_cmp++; if (leds !== 4'b0001) begin n_err++; $display("FAIL led_override_off: got %b expected 0001", leds); end
    step();
    set_bus(A_LED, 1'b0, 1'b1, 32'h0000_0000);
    n_cmp++; if (leds !== 4'b0001) begin n_err++; $display("FAIL led_bad_channel: got %b expected 0001", leds); end
    step();
    set_bus(12'd0, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (leds !== 4'b0000) begin n_err++; $display("FAIL led_all_off: got %b expected 0000", leds); end
  endtask

  task automatic test_unmapped();
    logic [11:0] a;
    for (int k = 0; k < 6; k++) begin
      a = (k < 3) ? 12'(k) : 12'($urandom_range(9, 4095));
      set_bus(a, 1'b1, 1'b1, $urandom);
      n_cmp++;
      if (hit !== 1'b0 || data_out !== 32'd0) begin
        n_err++; $display("FAIL unmapped a=%h: got hit=%b data=%h expected hit=0 data=0", a, hit, data_out);
      end
      step();
    end
    for (int k = 5; k <= 8; k++) begin
      set_bus(12'(k), 1'b0, 1'b0, 32'd0);
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL mapped_hit a=%0d: got %b expected 1", k, hit); end
    end
    set_bus(A_STAT, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== exp_read(A_STAT) || leds !== exp_leds()) begin
      n_err++; $display("FAIL unmapped_state: got %h/%b expected %h/%b", data_out, leds, exp_read(A_STAT), exp_leds());
    end
  endtask

  task automatic test_reset_mid();
    buttons[1] = 1'b1;
    set_bus(A_LED, 1'b0, 1'b1, 32'h0014_0103);
    step();
    set_bus(12'd0, 1'b0, 1'b0, 32'd0);
    repeat (8) step();
    reset = 1'b1;
    buttons = '0;
    step();
    reset = 1'b0;
    set_bus(A_RAND, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (leds !== '0) begin n_err++; $display("FAIL midreset_leds: got %b expected 0", leds); end
    n_cmp++; if (data_out !== 32'hACE1_0001) begin n_err++; $display("FAIL midreset_rand: got %h expected ACE10001", data_out); end
    repeat (DB + 6) step();
    set_bus(A_STAT, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL midreset_stat: got %h expected 0", data_out); end
    set_bus(A_BTN, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL midreset_btn: got %h expected 0", data_out); end
  endtask

  task automatic test_random();
    int          sel;
    int          b;
    logic [11:0] a;
    logic [31:0] d;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        b = $urandom_range(0, N_CH - 1);
        buttons[b] = ~buttons[b];
      end
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = A_RAND;
        1: a = A_LED;
        2, 5: a = A_BTN;
        3: a = A_STAT;
        default: a = 12'($urandom_range(0, 4095));
      endcase
      if (a == A_LED)
        d = {16'($urandom_range(0, 12)), 7'd0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 5))};
      else
        d = $urandom;
      set_bus(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), d);
      n_cmp++;
      if (hit !== ((a >= 12'd5) && (a <= 12'd8))) begin
        n_err++; $display("FAIL rnd_hit a=%h: got %b", a, hit);
      end
      if (a != A_LED) begin
        n_cmp++;
        if (data_out !== exp_read(a)) begin
          n_err++; $display("FAIL rnd_read a=%h: got %h expected %h", a, data_out, exp_read(a));
        end
      end
      n_cmp++;
      if (leds !== exp_leds()) begin
        n_err++; $display("FAIL rnd_leds: got %b expected %b", leds, exp_leds());
      end
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) step();
    test_reset();
    test_press_single();
    test_bounce();
    test_same_cycle();
    test_overflow();
    test_led();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_game_io.md
MMIO_GAME_IO -- requirements
Module: mmio_game_io

Interface
REQ-001 Parameter N_CH, default 4: number of button/LED channels; legal range 1..8.
REQ-002 Parameter DB_CYCLES, default 16: consecutive stable samples needed to accept a button level change.
REQ-003 Parameter FIFO_DEPTH, default 8: press-event FIFO entries; power of two, range 2..64.
REQ-004 Parameter RAND_ADDR, default 12'd5: random-number register address.
REQ-005 Parameter LED_ADDR, default 12'd6: LED control register address.
REQ-006 Parameter BTN_ADDR, default 12'd7: press-event pop register address.
REQ-007 Parameter STAT_ADDR, default 12'd8: status register address.
REQ-008 clock  in  1  single clock for all state.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 buttons  in  N_CH  raw asynchronous button inputs, 1 = pressed.
REQ-011 leds  out  N_CH  LED drives, 1 = lit.
REQ-012 addr  in  12  data-memory word address from the processor.
REQ-013 wren  in  1  store strobe, qualified by addr.
REQ-014 rden  in  1  load strobe, qualified by addr; gates FIFO pop only.
REQ-015 data_in  in  32  store data.
REQ-016 data_out  out  32  read data, combinational from addr and current state.
REQ-017 hit  out  1  high when addr equals any of the four register addresses.

Function
REQ-018 Each button passes through a 2-flop synchronizer, then a per-channel debounce counter.
REQ-019 Debounce: counter clears whenever the synchronized sample equals the stable level; otherwise increments; when it reaches DB_CYCLES-1 and still differs, the stable level takes the sample and the counter clears.
REQ-020 A stable-level 0->1 transition sets that channel's pending bit in the same cycle.
REQ-021 Each cycle the lowest-index pending bit is serviced: pushed as an event (channel index) if the FIFO is not full, else dropped with sticky overflow set; the serviced bit clears either way.
REQ-022 A FIFO pop (rden and addr==BTN_ADDR, FIFO non-empty) and a push in the same cycle both take effect; count unchanged.
REQ-023 Pop on an empty FIFO has no effect; a same-cycle push into an empty FIFO is not visible to that read.
REQ-024 Read BTN_ADDR: data_out[31] = non-empty, data_out[7:0] = head channel index, other bits 0; all zero when empty.
REQ-025 Read STAT_ADDR: bit0 overflow, bits[15:8] FIFO count, bits[16+N_CH-1:16] debounced levels, other bits 0.
REQ-026 Write STAT_ADDR with data_in[0]=1 clears overflow; an overflow event in the same cycle wins (flag stays 1).
REQ-027 Read RAND_ADDR returns the 32-bit LFSR (taps 32,22,2,1, shift left, feedback into bit0), which advances every cycle.
REQ-028 Write LED_ADDR: channel = data_in[7:0], on = data_in[8], duration = data_in[31:16]; channel >= N_CH ignored.
REQ-029 on=0: LED off, its timer cleared; on=1, duration=0: LED lit steadily; on=1, duration=D>0: LED lit exactly D cycles starting the cycle after the write, then off.
REQ-030 A new write to a channel overrides any running pulse; per-channel 16-bit down-counter, no wrap.
REQ-031 Reads of unmapped addresses return 0 with hit=0; writes ignored.

Reset
REQ-032 While reset is high at a clock edge: leds=0, synchronizers/stable levels/debounce counters/pending bits=0, FIFO empty, overflow=0, LED timers=0, LFSR=32'hACE1_0001.
REQ-033 Reset mid-pulse or mid-debounce abandons the operation; no event is produced from pre-reset state.

Verification
REQ-034 Hold buttons[2]=1 for DB_CYCLES+4 cycles, then read BTN_ADDR with rden -> data_out=32'h8000_0002, next read 32'h0.
REQ-035 Toggle buttons[0] every 5 cycles for 100 cycles (DB_CYCLES=16) -> no event, STAT bits[15:8]=0.
REQ-036 Press channels 1 and 3 in the same cycle -> events popped in order 1 then 3.
REQ-037 Generate FIFO_DEPTH+2 presses without reading -> count=FIFO_DEPTH, overflow=1; write STAT 32'h1 -> overflow=0.
REQ-038 Write LED_ADDR 32'h0005_0101 -> leds[1]=1 for exactly 5 cycles; write 32'h0000_0100 mid-pulse -> leds[0] steady lit.
REQ-039 Release reset, read RAND_ADDR on consecutive cycles -> 32'hACE1_0001 followed by the next LFSR state, never 0.
